// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, runs the imem read handshake, and feeds IF/ID.
// Holds at most one outstanding read and one buffered word; redirects never leak stale words.
module fetch_controller #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned PC_INCREMENT = 4,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_enable,
   input  logic [31:0] branch_address,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_busywait,
   input  logic [31:0] imem_readdata,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   typedef enum logic [1:0] {StFetch, StWait, StHold, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;

   logic        done;
   logic [31:0] branch_tgt;
   logic [31:0] pc_next;

   assign imem_read      = reset && (state_q != StHold);
   assign imem_address   = pc_q;
   assign done           = imem_read && !imem_busywait;
   assign branch_tgt     = branch_address & 32'hFFFF_FFFC;
   assign pc_next        = pc_q + 32'(PC_INCREMENT);
   assign if_instruction = if_instr_q;
   assign if_pc          = if_pc_q;
   assign if_valid       = if_valid_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      buf_d      = buf_q;
      buf_pc_d   = buf_pc_q;
      target_d   = target_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;

      case (state_q)
         StFetch, StWait: begin
            if (branch_enable) begin
               if_valid_d = 1'b0;
               if_instr_d = NOP_INSTR;
               if (done) begin
                  pc_d    = branch_tgt;
                  state_d = StFetch;
               end else begin
                  // pc must not move mid-read; the target is applied once the read drains
                  target_d = branch_tgt;
                  state_d  = StDrain;
               end
            end else if (!done) begin
               state_d = StWait;
               if (!stall) begin
                  if_valid_d = 1'b0;
                  if_instr_d = NOP_INSTR;
               end
            end else if (!stall) begin
               if_instr_d = imem_readdata;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_next;
               state_d    = StFetch;
            end else begin
               buf_d    = imem_readdata;
               buf_pc_d = pc_q;
               pc_d     = pc_next;
               state_d  = StHold;
            end
         end
         StHold: begin
            if (branch_enable) begin
               if_valid_d = 1'b0;
               if_instr_d = NOP_INSTR;
               pc_d       = branch_tgt;
               state_d    = StFetch;
            end else if (!stall) begin
               if_instr_d = buf_q;
               if_pc_d    = buf_pc_q;
               if_valid_d = 1'b1;
               state_d    = StFetch;
            end
         end
         StDrain: begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            if (branch_enable) target_d = branch_tgt;
            if (done) begin
               // newest redirect wins even when it lands on the completing edge
               pc_d    = branch_enable ? branch_tgt : target_q;
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= StFetch;
         pc_q       <= RESET_PC;
         buf_q      <= 32'h0;
         buf_pc_q   <= 32'h0;
         target_q   <= 32'h0;
         if_instr_q <= NOP_INSTR;
         if_pc_q    <= 32'h0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         buf_q      <= buf_d;
         buf_pc_q   <= buf_pc_d;
         target_q   <= target_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: a cycle table plus a hand-written stall-in-wait sequence.
module tb_fetch_controller;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] DKEY = 32'h1357_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_enable;
   logic [31:0] branch_address;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_busywait;
   logic [31:0] imem_readdata;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        if_valid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   // Memory model: the word at an address is the address xor a fixed key
   assign imem_readdata = imem_address ^ DKEY;

   fetch_controller dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .branch_enable  (branch_enable),
      .branch_address (branch_address),
      .imem_read      (imem_read),
      .imem_address   (imem_address),
      .imem_busywait  (imem_busywait),
      .imem_readdata  (imem_readdata),
      .if_instruction (if_instruction),
      .if_pc          (if_pc),
      .if_valid       (if_valid)
   );

   typedef struct {
      logic        rst;
      logic        stl;
      logic        br;
      logic [31:0] baddr;
      logic        busy;
      logic        chk_pre;
      logic        e_read;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stl, input logic br, input logic [31:0] baddr,
                      input logic busy, input logic chk_pre, input logic e_read,
                      input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.stl = stl; v.br = br; v.baddr = baddr; v.busy = busy;
      v.chk_pre = chk_pre; v.e_read = e_read; v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change after the falling edge; combinational outputs are checked before the rising
   // edge and registered outputs 1ns after it.
   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clock);
      reset          = v.rst;
      stall          = v.stl;
      branch_enable  = v.br;
      branch_address = v.baddr;
      imem_busywait  = v.busy;
      #1;
      if (v.chk_pre) begin
         chk($sformatf("v%0d imem_read", idx), {31'b0, imem_read}, {31'b0, v.e_read});
         chk($sformatf("v%0d imem_address", idx), imem_address, v.e_addr);
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d if_valid", idx), {31'b0, if_valid}, {31'b0, v.e_valid});
      chk($sformatf("v%0d if_pc", idx), if_pc, v.e_pc);
      chk($sformatf("v%0d if_instruction", idx), if_instruction,
          v.e_valid ? (v.e_pc ^ DKEY) : NOP);
   endtask

   initial begin
      vec_t v;
      reset = 1'b0; stall = 1'b0; branch_enable = 1'b0;
      branch_address = 32'h0; imem_busywait = 1'b0;

      //  rst stl br baddr          busy pre rd  addr           valid pc
      // T1: reset then zero-wait streaming
      add(0, 0, 0, 32'h0,          0,   0,  0,  32'h0,         0,    32'h0);
      add(0, 0, 0, 32'h0,          0,   1,  0,  32'h0,         0,    32'h0);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h0,         1,    32'h0);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h4,         1,    32'h4);
      // T2: three busy cycles at 8
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h8,         0,    32'h4);
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h8,         0,    32'h4);
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h8,         0,    32'h4);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h8,         1,    32'h8);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'hC,         1,    32'hC);
      // T3: stall on completion of 0x10 -> HOLD
      add(1, 1, 0, 32'h0,          0,   1,  1,  32'h10,        1,    32'hC);
      add(1, 1, 0, 32'h0,          0,   1,  0,  32'h14,        1,    32'hC);
      add(1, 0, 0, 32'h0,          0,   1,  0,  32'h14,        1,    32'h10);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h14,        1,    32'h14);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h18,        1,    32'h18);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h1C,        1,    32'h1C);
      // T4: branch while busy at 0x20 -> DRAIN
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h20,        0,    32'h1C);
      add(1, 0, 1, 32'h100,        1,   1,  1,  32'h20,        0,    32'h1C);
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h20,        0,    32'h1C);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h20,        0,    32'h1C);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h100,       1,    32'h100);
      // T5: branch in HOLD with stall, unaligned target
      add(1, 1, 0, 32'h0,          0,   1,  1,  32'h104,       1,    32'h100);
      add(1, 1, 1, 32'h203,        0,   1,  0,  32'h108,       0,    32'h100);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h200,       1,    32'h200);
      // branch on a completing edge in FETCH
      add(1, 0, 1, 32'h300,        0,   1,  1,  32'h204,       0,    32'h200);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h300,       1,    32'h300);
      // newest redirect wins on the DRAIN completion edge
      add(1, 0, 1, 32'h400,        1,   1,  1,  32'h304,       0,    32'h300);
      add(1, 0, 1, 32'h500,        0,   1,  1,  32'h304,       0,    32'h300);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h500,       1,    32'h500);
      // T6: PC wrap, then reset during WAIT
      add(1, 0, 1, 32'hFFFF_FFFC,  1,   1,  1,  32'h504,       0,    32'h500);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h504,       0,    32'h500);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'hFFFF_FFFC, 1,    32'hFFFF_FFFC);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h0,         1,    32'h0);
      add(1, 0, 0, 32'h0,          1,   1,  1,  32'h4,         0,    32'h0);
      add(0, 0, 0, 32'h0,          1,   1,  0,  32'h4,         0,    32'h0);
      add(1, 0, 0, 32'h0,          0,   1,  1,  32'h0,         1,    32'h0);

      foreach (vecs[i]) begin
         v = vecs[i];
         run_vec(i, v);
      end

      // Stall during a busy read: IF/ID keeps its valid word, address stays put
      @(negedge clock);
      stall = 1'b1; imem_busywait = 1'b1;
      #1;
      chk("sw pre addr", imem_address, 32'h4);
      @(posedge clock); #1;
      chk("sw hold valid", {31'b0, if_valid}, 32'h1);
      chk("sw hold pc", if_pc, 32'h0);
      chk("sw hold instr", if_instruction, 32'h0 ^ DKEY);
      @(negedge clock);
      chk("sw addr stable", imem_address, 32'h4);
      chk("sw read held", {31'b0, imem_read}, 32'h1);
      stall = 1'b0; imem_busywait = 1'b0;
      @(posedge clock); #1;
      chk("sw done valid", {31'b0, if_valid}, 32'h1);
      chk("sw done pc", if_pc, 32'h4);
      chk("sw done instr", if_instruction, 32'h4 ^ DKEY);
      chk("sw next addr", imem_address, 32'h8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
